// File: rtl/md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit and the decoder:
// MD opcodes, default latencies and the GPR write-data mux selects.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [2:0] {
    GPR_WD_ALU = 3'd0,
    GPR_WD_MEM = 3'd1,
    GPR_WD_PC8 = 3'd2,
    GPR_WD_HI  = 3'd3,
    GPR_WD_LO  = 3'd4
  } gpr_wd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // mult/multu/div/divu all have a clear top opcode bit.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Returns {hi,lo}; divide by zero and
// non-arithmetic opcodes return the current HI/LO unchanged.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_cur_hi,
  input  logic [31:0] i_cur_lo,
  output logic [63:0] o_res
);

  logic        w_b_zero;
  logic        w_div_ovf;
  logic [31:0] w_squot;
  logic [31:0] w_srem;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;

  assign w_b_zero  = (i_b == 32'd0);
  // The only signed quotient that does not fit in 32 bits.
  assign w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  assign w_squot = $signed(i_a) / $signed(i_b);
  assign w_srem  = $signed(i_a) % $signed(i_b);
  assign w_uquot = i_a / i_b;
  assign w_urem  = i_a % i_b;

  // NOTE: o_res gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_res = {i_cur_hi, i_cur_lo};
    case (i_op)
      MD_MULT:  o_res = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
      MD_MULTU: o_res = {32'd0, i_a} * {32'd0, i_b};
      MD_DIV: begin
        if (w_div_ovf)      o_res = {32'd0, 32'h8000_0000};
        else if (!w_b_zero) o_res = {w_srem, w_squot};
      end
      MD_DIVU: begin
        if (!w_b_zero) o_res = {w_urem, w_uquot};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO ownership. Results are computed at
// start, held in shadow registers and committed when the busy period ends.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_req_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic [3:0]  r_count;
  logic [3:0]  w_count_nxt;
  logic [31:0] r_shadow_hi;
  logic [31:0] r_shadow_lo;
  logic [31:0] w_shadow_hi_nxt;
  logic [31:0] w_shadow_lo_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [63:0] w_res;

  md_arith u_arith (
    .i_op     (md_op),
    .i_a      (rs_val),
    .i_b      (rt_val),
    .i_cur_hi (r_hi),
    .i_cur_lo (r_lo),
    .o_res    (w_res)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_shadow_hi_nxt = r_shadow_hi;
    w_shadow_lo_nxt = r_shadow_lo;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    case (r_state)
      MD_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              {w_shadow_hi_nxt, w_shadow_lo_nxt} = w_res;
              w_count_nxt = MULT_CNT;
              w_state_nxt = MD_RUN;
            end
            MD_DIV, MD_DIVU: begin
              {w_shadow_hi_nxt, w_shadow_lo_nxt} = w_res;
              w_count_nxt = DIV_CNT;
              w_state_nxt = MD_RUN;
            end
            MD_MTHI: w_hi_nxt = rs_val;
            MD_MTLO: w_lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        // A start arriving here is ignored; the stall protocol keeps it from happening.
        if (r_count != 4'd0) begin
          w_count_nxt = r_count - 4'd1;
        end else begin
          w_hi_nxt    = r_shadow_hi;
          w_lo_nxt    = r_shadow_lo;
          w_state_nxt = MD_IDLE;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; shadow regs are reset too so an
  // abandoned operation leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= MD_IDLE;
      r_count     <= 4'd0;
      r_shadow_hi <= 32'd0;
      r_shadow_lo <= 32'd0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_shadow_hi <= w_shadow_hi_nxt;
      r_shadow_lo <= w_shadow_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
    end
  end

  assign busy     = (r_state == MD_RUN);
  assign md_stall = md_req_d & (busy | (start & md_is_arith(md_op)));
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Owns the HI/LO registers.
- Executes mult/multu/div/divu over a fixed number of cycles. Executes mthi/mtlo in one cycle.
- Is the source end of the stall interface: it drives md_stall, which the stall controller ORs into its freeze condition (IF/ID hold, ID/EX clear, PC write disable).

Parameters:
- MULT_LAT, 5, cycles busy is high after a mult/multu start.
- DIV_LAT, 10, cycles busy is high after a div/divu start.

Ports:
- clk  input  1  pipeline clock. Rising edge.
- rst_n  input  1  reset. Asynchronous, active-low.
- start  input  1  EX-stage instruction is an MD operation; qualifies md_op.
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 are no-op.
- rs_val  input  32  forwarded GPR[rs] in EX.
- rt_val  input  32  forwarded GPR[rt] in EX.
- md_req_d  input  1  D-stage instruction is MD-class (mult/div/mthi/mtlo/mfhi/mflo).
- busy  output  1  multi-cycle operation in progress.
- md_stall  output  1  stall request to the stall controller.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: while rst_n=0, asynchronously force busy=0, hi=0, lo=0, count=0 and shadow regs=0. Reset mid-operation abandons the operation; no commit occurs.
- States: IDLE (busy=0) and RUN (busy=1). count[3:0] is a down-counter.
- IDLE, start=1, md_op in {000..011}, edge:
  - Latch the result into shadow_hi/shadow_lo.
  - Load count=MULT_LAT-1 or DIV_LAT-1. Go to RUN.
- RUN, each edge:
  - If count!=0, count-=1.
  - If count==0, commit hi<=shadow_hi, lo<=shadow_lo and return to IDLE.
  - busy is therefore high for exactly MULT_LAT or DIV_LAT cycles starting the cycle after the start edge. New hi/lo are visible in the cycle busy falls.
- mthi/mtlo (IDLE, start=1): next edge writes hi<=rs_val or lo<=rs_val. No RUN. The other register is unchanged.
- Opcodes 110/111 with start=1: no state change.
- start=1 while busy=1: ignored. The stall protocol makes this illegal; the bench asserts it never happens.
- mult: signed 32x32 to 64-bit; hi=[63:32], lo=[31:0].
- multu: unsigned 32x32 to 64-bit; hi=[63:32], lo=[31:0].
- div: signed; lo=quotient truncated toward 0, hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned; lo=quotient, hi=remainder.
- Divide by zero (rt_val=0): full DIV_LAT busy period, then hi/lo unchanged (shadow loaded from the current hi/lo).
- md_stall = md_req_d & (busy | (start & md_op in {000..011})). Combinational, so the start cycle is covered before busy rises.
  - mthi/mtlo alone never stall.
  - When busy falls, md_stall falls in the same cycle, so a waiting mfhi/mflo in D proceeds and reads the committed value.
- hi and lo are registered outputs. No forwarding inside the block; mfhi/mflo read hi/lo in EX.

Decomposition:
- Shared package holds:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO opcode constants.
  - Default latency constants.
  - GPR_WD_MUX select encodings, reused by the decoder.
- One natural sub-module: md_arith. Purely combinational; takes op/a/b/cur_hi/cur_lo and returns the 64-bit {res_hi,res_lo}, including the div-by-zero hold and the signed-overflow rule.
- Sequencing, counter and HI/LO registers stay in md_unit.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3, start 1 cycle → busy high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA when busy falls; hi/lo unchanged before.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div rs=-7 (0xFFFFFFF9), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu rt=0 with prior hi=0x11, lo=0x22 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- md_req_d=1 held from the start cycle through a div → md_stall=1 on the start cycle and all 10 busy cycles, 0 in the cycle busy falls.
- mtlo rs=0xABCD with md_req_d=1 → lo=0xABCD next edge, md_stall=0.
- rst_n pulled low at cycle 3 of a mult → busy/hi/lo=0 immediately; no commit after release.
